// File: rtl/bus1_arbiter_if.sv
// Requester ports and cache-side bus-1 pins of the two-master C1/A1/D1 arbiter.
// The arbiter takes the master modport; requesters and the cache model take slave.
interface bus1_arbiter_if #(
    parameter int ADDR1_BUS_SIZE = 15,
    parameter int DATA_BUS_SIZE  = 16,
    parameter int CTR1_BUS_SIZE  = 3
);
    logic [1:0][CTR1_BUS_SIZE-1:0]  rq_cmd;
    logic [1:0][ADDR1_BUS_SIZE-1:0] rq_addr;
    logic [1:0][DATA_BUS_SIZE-1:0]  rq_wdata;
    logic [1:0]                     rq_grant;
    logic [1:0]                     rq_done;
    logic [1:0][DATA_BUS_SIZE-1:0]  rq_rdata;
    logic [1:0]                     rq_err;

    logic [CTR1_BUS_SIZE-1:0]       c1_out;
    logic [CTR1_BUS_SIZE-1:0]       c1_in;
    logic [ADDR1_BUS_SIZE-1:0]      a1_out;
    logic [DATA_BUS_SIZE-1:0]       d1_out;
    logic [DATA_BUS_SIZE-1:0]       d1_in;
    logic                           bus_oe;

    modport master (
        input  rq_cmd, rq_addr, rq_wdata, c1_in, d1_in,
        output rq_grant, rq_done, rq_rdata, rq_err, c1_out, a1_out, d1_out, bus_oe
    );

    modport slave (
        output rq_cmd, rq_addr, rq_wdata, c1_in, d1_in,
        input  rq_grant, rq_done, rq_rdata, rq_err, c1_out, a1_out, d1_out, bus_oe
    );
endinterface

// File: rtl/bus1_arbiter.sv
// Round-robin arbiter for two C1 requesters sharing the cache bus-1 pins.
// Replays the owner's transaction in two address phases, then releases the bus for the response.
module bus1_arbiter #(
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int DATA_BUS_SIZE     = 16,
    parameter int CTR1_BUS_SIZE     = 3,
    parameter int MAX_WAIT          = 255
) (
    input  logic          CLK,
    input  logic          RESET,
    bus1_arbiter_if.master bus
);

    localparam int WD_W = $clog2(MAX_WAIT + 1);

    typedef logic [CTR1_BUS_SIZE-1:0]  cmd_t;
    typedef logic [ADDR1_BUS_SIZE-1:0] addr_t;
    typedef logic [DATA_BUS_SIZE-1:0]  data_t;

    localparam cmd_t CMD_NOP      = cmd_t'(0);
    localparam cmd_t CMD_READ8    = cmd_t'(1);
    localparam cmd_t CMD_READ16   = cmd_t'(2);
    localparam cmd_t CMD_READ32   = cmd_t'(3);
    localparam cmd_t CMD_WRITE32  = cmd_t'(7);
    localparam cmd_t CMD_RESPONSE = cmd_t'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR1,
        S_ADDR2,
        S_RELEASE,
        S_WAIT,
        S_RDBEAT2,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_last_q, rr_last_d;
    cmd_t              cmd_q, cmd_d;
    addr_t             addr_q, addr_d;
    data_t             wbeat_q, wbeat_d;
    data_t             rbeat1_q, rbeat1_d;
    data_t             rbeat2_q, rbeat2_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic [1:0]        grant_q, grant_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [1:0][DATA_BUS_SIZE-1:0] rdata_q, rdata_d;
    cmd_t              c1_q, c1_d;
    addr_t             a1_q, a1_d;
    data_t             d1_q, d1_d;
    logic              oe_q, oe_d;

    logic [1:0]        pend;
    logic              win;

    assign pend[0] = (bus.rq_cmd[0] != CMD_NOP);
    assign pend[1] = (bus.rq_cmd[1] != CMD_NOP);

    // READ8 returns a single byte; wider reads return the whole beat, writes return nothing.
    function automatic data_t read_beat(cmd_t c, data_t d);
        data_t r;
        r = '0;
        if (c == CMD_READ8) begin
            r[7:0] = d[7:0];
        end else if (c == CMD_READ16 || c == CMD_READ32) begin
            r = d;
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wbeat_d   = wbeat_q;
        rbeat1_d  = rbeat1_q;
        rbeat2_d  = rbeat2_q;
        wd_cnt_d  = wd_cnt_q;
        grant_d   = '0;
        done_d    = '0;
        err_d     = '0;
        rdata_d   = '0;
        c1_d      = c1_q;
        a1_d      = a1_q;
        d1_d      = d1_q;
        oe_d      = oe_q;
        win       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                oe_d = 1'b0;
                c1_d = CMD_NOP;
                a1_d = '0;
                d1_d = '0;
                if (pend != 2'b00) begin
                    // On a tie the requester that did not win last time gets the bus.
                    win       = (pend == 2'b11) ? ~rr_last_q : ~pend[0];
                    owner_d   = win;
                    rr_last_d = win;
                    cmd_d     = bus.rq_cmd[win];
                    addr_d    = bus.rq_addr[win];
                    wbeat_d   = bus.rq_wdata[win];
                    grant_d[win] = 1'b1;
                    state_d   = S_ADDR1;
                end
            end
            S_ADDR1: begin
                oe_d    = 1'b1;
                c1_d    = cmd_q;
                a1_d    = addr_q >> CACHE_OFFSET_SIZE;
                d1_d    = wbeat_q;
                state_d = S_ADDR2;
            end
            S_ADDR2: begin
                c1_d    = cmd_q;
                a1_d    = addr_t'(addr_q[CACHE_OFFSET_SIZE-1:0]);
                // WRITE32 beat 2 comes straight from the owner, one cycle after its grant.
                d1_d    = (cmd_q == CMD_WRITE32) ? bus.rq_wdata[owner_q] : wbeat_q;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                oe_d     = 1'b0;
                c1_d     = CMD_NOP;
                a1_d     = '0;
                d1_d     = '0;
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (bus.c1_in == CMD_RESPONSE && !oe_q) begin
                    if (cmd_q == CMD_READ32) begin
                        rbeat1_d = bus.d1_in;
                        state_d  = S_RDBEAT2;
                    end else begin
                        done_d[owner_q]  = 1'b1;
                        rdata_d[owner_q] = read_beat(cmd_q, bus.d1_in);
                        state_d          = S_DONE;
                    end
                end else if (wd_cnt_q == WD_W'(MAX_WAIT - 1)) begin
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    state_d         = S_DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            S_RDBEAT2: begin
                rbeat2_d         = bus.d1_in;
                done_d[owner_q]  = 1'b1;
                rdata_d[owner_q] = rbeat1_q;
                state_d          = S_DONE;
            end
            S_DONE: begin
                if (cmd_q == CMD_READ32 && !err_q[owner_q]) begin
                    rdata_d[owner_q] = rbeat2_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            wbeat_q   <= '0;
            rbeat1_q  <= '0;
            rbeat2_q  <= '0;
            wd_cnt_q  <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            c1_q      <= CMD_NOP;
            a1_q      <= '0;
            d1_q      <= '0;
            oe_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge values of the others.
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wbeat_q   <= wbeat_d;
            rbeat1_q  <= rbeat1_d;
            rbeat2_q  <= rbeat2_d;
            wd_cnt_q  <= wd_cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            c1_q      <= c1_d;
            a1_q      <= a1_d;
            d1_q      <= d1_d;
            oe_q      <= oe_d;
        end
    end

    assign bus.rq_grant = grant_q;
    assign bus.rq_done  = done_q;
    assign bus.rq_err   = err_q;
    assign bus.rq_rdata = rdata_q;
    assign bus.c1_out   = c1_q;
    assign bus.a1_out   = a1_q;
    assign bus.d1_out   = d1_q;
    assign bus.bus_oe   = oe_q;

    grant_onehot_a: assert property (@(posedge CLK) disable iff (RESET) !(grant_q[0] && grant_q[1]));
    done_onehot_a:  assert property (@(posedge CLK) disable iff (RESET) !(done_q[0] && done_q[1]));

endmodule

// File: tb/tb_bus1_arbiter.sv
// Bench for bus1_arbiter: directed cases then random rounds, each transaction checked
// against timing and data derived from the arbitration rules, not from the RTL.
module tb_bus1_arbiter;

    localparam int AW  = 15;
    localparam int OFF = 4;
    localparam int DW  = 16;
    localparam int CW  = 3;
    localparam int MW  = 8;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] RD8  = 3'd1;
    localparam logic [2:0] RD16 = 3'd2;
    localparam logic [2:0] RD32 = 3'd3;
    localparam logic [2:0] INV  = 3'd4;
    localparam logic [2:0] WR32 = 3'd7;
    localparam logic [2:0] RESP = 3'd7;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    bus1_arbiter_if #(.ADDR1_BUS_SIZE(AW), .DATA_BUS_SIZE(DW), .CTR1_BUS_SIZE(CW)) bus ();

    bus1_arbiter #(
        .ADDR1_BUS_SIZE(AW), .CACHE_OFFSET_SIZE(OFF), .DATA_BUS_SIZE(DW),
        .CTR1_BUS_SIZE(CW), .MAX_WAIT(MW)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int last_m   = 1;

    logic [2:0]  t_cmd [2];
    logic [14:0] t_addr[2];
    logic [15:0] t_w1  [2];
    logic [15:0] t_w2  [2];
    logic [15:0] t_b1  [2];
    logic [15:0] t_b2  [2];
    int          t_dly [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] c, input logic [14:0] a,
                           input logic [15:0] w1, input logic [15:0] w2, input int dly,
                           input logic [15:0] b1, input logic [15:0] b2);
        t_cmd[i] = c; t_addr[i] = a; t_w1[i] = w1; t_w2[i] = w2;
        t_dly[i] = dly; t_b1[i] = b1; t_b2[i] = b2;
        bus.rq_cmd[i]   = c;
        bus.rq_addr[i]  = a;
        bus.rq_wdata[i] = w1;
    endtask

    task automatic rand_req(input int i);
        int dly;
        dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 7));
        set_req(i, 3'($urandom_range(1, 7)), 15'($urandom), 16'($urandom), 16'($urandom),
                dly, 16'($urandom), 16'($urandom));
    endtask

    function automatic logic [15:0] exp_rdata(input logic [2:0] c, input logic [15:0] b);
        if (c == RD8) return {8'h00, b[7:0]};
        return b;
    endfunction

    function automatic int pick(input logic [1:0] p, input int last);
        if (p == 2'b11) return 1 - last;
        return p[0] ? 0 : 1;
    endfunction

    // One granted transaction, cycle by cycle, acting as the cache for the response.
    task automatic do_txn(input int w, input bit may_reassert, output bit reasserted);
        bit          seen;
        bit          timeout;
        bit          is_read;
        int          exp_k;
        int          dly;
        logic [2:0]  cmd;
        logic [15:0] b2;
        reasserted = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge CLK);
            if (bus.rq_grant != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        check("grant", 32'(bus.rq_grant), 32'(1 << w));
        if (!seen) return;
        cmd = t_cmd[w];
        b2  = t_b2[w];
        dly = t_dly[w];
        bus.rq_cmd[w] = NOP;
        if (cmd == WR32) bus.rq_wdata[w] = t_w2[w];

        @(negedge CLK);
        check("ph1_cmd",  32'(bus.c1_out), 32'(cmd));
        check("ph1_addr", 32'(bus.a1_out), 32'(t_addr[w] >> OFF));
        check("ph1_data", 32'(bus.d1_out), 32'(t_w1[w]));
        check("ph1_oe",   32'(bus.bus_oe), 32'd1);
        check("grant_pulse", 32'(bus.rq_grant), 32'd0);

        @(negedge CLK);
        check("ph2_cmd",  32'(bus.c1_out), 32'(cmd));
        check("ph2_addr", 32'(bus.a1_out), 32'(t_addr[w][3:0]));
        check("ph2_data", 32'(bus.d1_out), 32'((cmd == WR32) ? t_w2[w] : t_w1[w]));
        check("ph2_oe",   32'(bus.bus_oe), 32'd1);

        @(negedge CLK);
        check("rel_oe",  32'(bus.bus_oe), 32'd0);
        check("rel_cmd", 32'(bus.c1_out), 32'(NOP));

        timeout = (dly < 0);
        is_read = (cmd == RD8 || cmd == RD16 || cmd == RD32);
        exp_k   = timeout ? MW : dly + ((cmd == RD32) ? 2 : 1);
        for (int k = 0; k <= exp_k; k++) begin
            if (k > 0) @(negedge CLK);
            if (k < exp_k) begin
                check("early_done", 32'(bus.rq_done), 32'd0);
            end else begin
                check("done", 32'(bus.rq_done), 32'(1 << w));
                check("err",  32'(bus.rq_err), timeout ? 32'(1 << w) : 32'd0);
                if (!timeout && is_read)
                    check("rdata", 32'(bus.rq_rdata[w]), 32'(exp_rdata(cmd, t_b1[w])));
            end
            if (!timeout && k == dly) begin
                bus.c1_in = RESP;
                bus.d1_in = t_b1[w];
            end else begin
                bus.c1_in = NOP;
                bus.d1_in = (k == dly + 1) ? b2 : 16'($urandom);
            end
        end
        if (may_reassert && $urandom_range(0, 1) == 1) begin
            rand_req(w);
            reasserted = 1'b1;
        end
        if (!timeout && cmd == RD32) begin
            @(negedge CLK);
            check("rd32_beat2", 32'(bus.rq_rdata[w]), 32'(b2));
            check("done_once",  32'(bus.rq_done), 32'd0);
        end
    endtask

    // Serves every pending requester in the order the round-robin rules dictate.
    task automatic run_round(input int budget);
        logic [1:0] p;
        int         w;
        bit         re;
        p = {bus.rq_cmd[1] != NOP, bus.rq_cmd[0] != NOP};
        for (int g = 0; g < 8 && p != 2'b00; g++) begin
            w = pick(p, last_m);
            last_m = w;
            do_txn(w, budget > 0, re);
            if (re) budget--;
            p[w] = re;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_oe"},    32'(bus.bus_oe),   32'd0);
        check({tag, "_c1"},    32'(bus.c1_out),   32'(NOP));
        check({tag, "_a1"},    32'(bus.a1_out),   32'd0);
        check({tag, "_d1"},    32'(bus.d1_out),   32'd0);
        check({tag, "_grant"}, 32'(bus.rq_grant), 32'd0);
        check({tag, "_done"},  32'(bus.rq_done),  32'd0);
        check({tag, "_err"},   32'(bus.rq_err),   32'd0);
        check({tag, "_rdata"}, 32'(bus.rq_rdata), 32'd0);
    endtask

    task automatic reset_mid_wait();
        bit seen;
        set_req(0, INV, 15'h02A7, 16'h0F0F, 16'h0, -1, 16'h0, 16'h0);
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge CLK);
            if (bus.rq_grant != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        check("inv_grant", 32'(bus.rq_grant), 32'd1);
        bus.rq_cmd[0] = NOP;
        repeat (6) @(negedge CLK);
        #2 RESET = 1'b1;
        #1 check_quiet("rst_async");
        @(negedge CLK);
        RESET  = 1'b0;
        last_m = 1;
        for (int k = 0; k < 4; k++) begin
            bus.c1_in = RESP;
            bus.d1_in = 16'h1234;
            @(negedge CLK);
            check("late_resp_done", 32'(bus.rq_done), 32'd0);
            check("late_resp_oe",   32'(bus.bus_oe),  32'd0);
        end
        bus.c1_in = NOP;
    endtask

    initial begin
        logic [1:0] mask;
        bus.rq_cmd   = '0;
        bus.rq_addr  = '0;
        bus.rq_wdata = '0;
        bus.c1_in    = NOP;
        bus.d1_in    = '0;
        repeat (3) @(negedge CLK);
        check_quiet("reset");

        // Tie at reset exit: R0, R1, then R0, R1 again.
        set_req(0, RD8, 15'h0011, 16'h0, 16'h0, 1, 16'hA5C3, 16'h0);
        set_req(1, RD8, 15'h0722, 16'h0, 16'h0, 0, 16'h5A3C, 16'h0);
        RESET = 1'b0;
        run_round(0);
        set_req(0, RD8, 15'h0133, 16'h0, 16'h0, 2, 16'h77FE, 16'h0);
        set_req(1, RD8, 15'h0244, 16'h0, 16'h0, 4, 16'h8801, 16'h0);
        run_round(0);

        set_req(0, RD16, 15'h1235, 16'h0, 16'h0, 6, 16'hBEEF, 16'h0);
        run_round(0);
        set_req(0, RD32, 15'h0100, 16'h0, 16'h0, 2, 16'hAAAA, 16'h5555);
        run_round(0);
        set_req(1, WR32, 15'h0040, 16'h1122, 16'h3344, 3, 16'hDEAD, 16'h0);
        run_round(0);

        // Watchdog on R0 while R1 waits; R1 is served afterwards.
        set_req(0, RD16, 15'h0300, 16'h0, 16'h0, -1, 16'h0, 16'h0);
        set_req(1, RD8,  15'h0401, 16'h0, 16'h0, 1, 16'h00C7, 16'h0);
        run_round(0);

        reset_mid_wait();

        set_req(0, RD16, 15'h0505, 16'h0, 16'h0, 0, 16'h4242, 16'h0);
        set_req(1, RD16, 15'h0606, 16'h0, 16'h0, 0, 16'h2424, 16'h0);
        run_round(0);

        repeat (40) begin
            mask = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                if (mask[i]) rand_req(i);
                else bus.rq_cmd[i] = NOP;
            end
            run_round(2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
